// File: rtl/sar_pkg.sv
// Shared state encoding, default width and small helpers for the
// successive-approximation search block.
package sar_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of the bit-index counter; a 1-bit search still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Handshake and comparator bundle between the search initiator (slave side)
// and its environment: start request, comparator flags, probe and result.
interface sar_search_if
    import sar_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic         start;
    logic         EQ;
    logic         LT;
    logic [N-1:0] probe;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         found;

    // Environment: issues start and returns comparator flags for the probe.
    modport master (
        output start, EQ, LT,
        input  probe, busy, done, result, found
    );

    // Search initiator.
    modport slave (
        input  start, EQ, LT,
        output probe, busy, done, result, found
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation initiator: walks a probe MSB-first against an
// external comparator and reports the located value with an EQ confirmation.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    sar_search_if.slave  bus
);

    localparam int unsigned    IW      = idx_width(N);
    localparam logic [N-1:0]   ONE     = N'(1);
    localparam logic [N-1:0]   TOP     = ONE << (N - 1);
    localparam logic [IW-1:0]  IDX_TOP = IW'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  trial_q, trial_d;
    logic [N-1:0]  probe_q, probe_d;
    logic [N-1:0]  result_q, result_d;
    logic          found_q, found_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  cand;
    logic [N-1:0]  kept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= IDX_TOP;
            trial_q  <= '0;
            probe_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            found_q  <= found_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        probe_d  = probe_q;
        result_d = result_q;
        found_d  = found_q;
        cand     = trial_q | (ONE << idx_q);
        // LT means the candidate bit still undershoots the target, so keep it.
        kept     = bus.LT ? cand : trial_q;

        unique case (state_q)
            IDLE: begin
                probe_d = '0;
                if (bus.start) begin
                    state_d  = PROBE;
                    idx_d    = IDX_TOP;
                    trial_d  = '0;
                    probe_d  = TOP;
                    result_d = '0;
                    found_d  = 1'b0;
                end
            end
            PROBE: begin
                if (bus.EQ) begin
                    result_d = cand;
                    found_d  = 1'b1;
                    probe_d  = '0;
                    state_d  = DONE;
                end else begin
                    trial_d = kept;
                    if (idx_q == '0) begin
                        probe_d = kept;
                        state_d = VERIFY;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        probe_d = kept | (ONE << (idx_q - IW'(1)));
                    end
                end
            end
            VERIFY: begin
                result_d = trial_q;
                found_d  = bus.EQ;
                probe_d  = '0;
                state_d  = DONE;
            end
            DONE: begin
                probe_d = '0;
                idx_d   = IDX_TOP;
                trial_d = '0;
                state_d = IDLE;
            end
            default: begin
                probe_d = '0;
                state_d = IDLE;
            end
        endcase

        // Flags are registered from the next state so they line up with it.
        busy_d = (state_d == PROBE) || (state_d == VERIFY);
        done_d = (state_d == DONE);
    end

    assign bus.probe  = probe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed table, hand-written corner
// sequences and randomized targets against a behavioural search model.
module tb_sar_search;
    import sar_pkg::*;

    localparam int unsigned W   = 8;
    localparam int          WIN = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] target;
    logic         illegal;

    int checks   = 0;
    int failures = 0;

    sar_search_if #(.N(W)) bus ();

    sar_search #(.N(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparator; 'illegal' forces both flags high.
    always_comb begin
        bus.EQ = (bus.probe == target) | illegal;
        bus.LT = (bus.probe <  target) | illegal;
    end

    // Observed run
    logic [W-1:0] obs_probe [WIN];
    int           obs_n;
    int           obs_done_cyc;
    int           obs_ndone;
    int           obs_busy_after;
    logic [W-1:0] obs_result;
    logic         obs_found;
    logic [W-1:0] obs_probe_at_done;

    // Model expectations
    logic [W-1:0] exp_probe [WIN];
    int           exp_n;
    int           exp_done_cyc;
    logic [W-1:0] exp_result;
    logic         exp_found;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Binary search over the value range: the target seen at step k is t0
    // before step chg and t1 from it on (chg=0 means no change).
    task automatic model(input logic [W-1:0] t0, input int chg, input logic [W-1:0] t1);
        int unsigned acc;
        int unsigned p;
        int unsigned t;
        acc   = 0;
        exp_n = 0;
        for (int k = 1; k <= W + 1; k++) begin
            t = (chg > 0 && k >= chg) ? int'(t1) : int'(t0);
            if (k == W + 1) begin
                exp_probe[exp_n] = W'(acc);
                exp_n++;
                exp_result   = W'(acc);
                exp_found    = (acc == t);
                exp_done_cyc = W + 2;
                return;
            end
            p = acc + (2 ** (W - k));
            exp_probe[exp_n] = W'(p);
            exp_n++;
            if (p == t) begin
                exp_result   = W'(p);
                exp_found    = 1'b1;
                exp_done_cyc = k + 1;
                return;
            end
            if (p < t) acc = p;
        end
    endtask

    // One search; cycle c is the period after the c-th rising edge following
    // the start edge. Optional target change, stray start while busy, and
    // a start pulse during the done cycle.
    task automatic run_search(input logic [W-1:0] t0, input int chg, input logic [W-1:0] t1,
                              input int glitch, input bit start_in_done);
        target         = t0;
        obs_n          = 0;
        obs_done_cyc   = -1;
        obs_ndone      = 0;
        obs_busy_after = 0;
        obs_result     = '0;
        obs_found      = 1'b0;
        obs_probe_at_done = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= WIN; cyc++) begin
            if (chg > 0 && cyc == chg) target = t1;
            if (cyc == glitch) bus.start = 1'b1;
            if (bus.busy) begin
                if (obs_n < WIN) obs_probe[obs_n] = bus.probe;
                obs_n++;
                if (obs_done_cyc > 0) obs_busy_after++;
            end
            if (bus.done) begin
                obs_ndone++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc      = cyc;
                    obs_result        = bus.result;
                    obs_found         = bus.found;
                    obs_probe_at_done = bus.probe;
                    if (start_in_done) bus.start = 1'b1;
                end
            end
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_against_model(input string tag);
        check({tag, ".ndone"}, obs_ndone, 1);
        check({tag, ".done_cyc"}, obs_done_cyc, exp_done_cyc);
        check({tag, ".result"}, int'(obs_result), int'(exp_result));
        check({tag, ".found"}, int'(obs_found), int'(exp_found));
        check({tag, ".nprobe"}, obs_n, exp_n);
        for (int j = 0; j < exp_n && j < obs_n && j < WIN; j++)
            check($sformatf("%s.probe%0d", tag, j), int'(obs_probe[j]), int'(exp_probe[j]));
        check({tag, ".probe_in_done"}, int'(obs_probe_at_done), 0);
        check({tag, ".busy_after"}, obs_busy_after, 0);
    endtask

    typedef struct {
        logic [W-1:0] tgt;
        bit           ill;
        logic [W-1:0] res;
        bit           fnd;
        int           dcyc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{tgt: 8'h80, ill: 1'b0, res: 8'h80, fnd: 1'b1, dcyc: 2};
        vecs[1] = '{tgt: 8'hFF, ill: 1'b0, res: 8'hFF, fnd: 1'b1, dcyc: 9};
        vecs[2] = '{tgt: 8'h00, ill: 1'b0, res: 8'h00, fnd: 1'b1, dcyc: 10};
        vecs[3] = '{tgt: 8'h5A, ill: 1'b0, res: 8'h5A, fnd: 1'b1, dcyc: 8};
        vecs[4] = '{tgt: 8'h01, ill: 1'b0, res: 8'h01, fnd: 1'b1, dcyc: 9};
        vecs[5] = '{tgt: 8'h90, ill: 1'b1, res: 8'h80, fnd: 1'b1, dcyc: 2};

        rst       = 1'b0;
        bus.start = 1'b0;
        target    = '0;
        illegal   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.probe", int'(bus.probe), 0);
        check("rst.busy", int'(bus.busy), 0);
        check("rst.done", int'(bus.done), 0);
        check("rst.result", int'(bus.result), 0);
        check("rst.found", int'(bus.found), 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table
        foreach (vecs[v]) begin
            illegal = vecs[v].ill;
            run_search(vecs[v].tgt, 0, '0, 0, 1'b0);
            illegal = 1'b0;
            check($sformatf("vec%0d.result", v), int'(obs_result), int'(vecs[v].res));
            check($sformatf("vec%0d.found", v), int'(obs_found), int'(vecs[v].fnd));
            check($sformatf("vec%0d.done_cyc", v), obs_done_cyc, vecs[v].dcyc);
            check($sformatf("vec%0d.ndone", v), obs_ndone, 1);
            if (!vecs[v].ill) begin
                model(vecs[v].tgt, 0, '0);
                check_against_model($sformatf("vec%0d", v));
            end
        end

        // Stray start while busy and during done: neither may start a search
        run_search(8'h5A, 0, '0, 3, 1'b1);
        check("midstart.result", int'(obs_result), 8'h5A);
        check("midstart.found", int'(obs_found), 1);
        check("midstart.ndone", obs_ndone, 1);
        check("midstart.busy_after", obs_busy_after, 0);

        // Target moved 0x5A -> 0x10 at step 4
        run_search(8'h5A, 4, 8'h10, 0, 1'b0);
        check("chg.result", int'(obs_result), 8'h40);
        check("chg.found", int'(obs_found), 0);
        check("chg.done_cyc", obs_done_cyc, 10);
        model(8'h5A, 4, 8'h10);
        check_against_model("chg");

        // Reset asserted during step 3
        target = 8'h5A;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("prerst.busy", int'(bus.busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst.probe", int'(bus.probe), 0);
        check("midrst.busy", int'(bus.busy), 0);
        check("midrst.done", int'(bus.done), 0);
        check("midrst.result", int'(bus.result), 0);
        check("midrst.found", int'(bus.found), 0);
        obs_ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.busy) obs_ndone++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) obs_ndone++;
        end
        check("midrst.quiet", obs_ndone, 0);
        run_search(8'h33, 0, '0, 0, 1'b0);
        check("postrst.result", int'(obs_result), 8'h33);
        check("postrst.found", int'(obs_found), 1);
        check("postrst.done_cyc", obs_done_cyc, 9);

        // Randomized targets, sometimes moved mid-search
        for (int r = 0; r < 25; r++) begin
            logic [W-1:0] t0;
            logic [W-1:0] t1;
            int           chg;
            t0  = W'($urandom_range(0, 255));
            t1  = W'($urandom_range(0, 255));
            chg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
            model(t0, chg, t1);
            run_search(t0, chg, t1, 0, 1'b0);
            check_against_model($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001: Parameter N, default 8, is the width of the probe, the target and the result.
REQ-002: Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003: Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004: Port start, input, 1 bit: request a new search; sampled only in IDLE.
REQ-005: Port EQ, input, 1 bit: external comparator result, probe == target.
REQ-006: Port LT, input, 1 bit: external comparator result, probe < target (unsigned).
REQ-007: Port probe, output, N bits: registered value driven to the comparator A input.
REQ-008: Port busy, output, 1 bit: high in PROBE and VERIFY.
REQ-009: Port done, output, 1 bit: one-cycle pulse when result and found are valid.
REQ-010: Port result, output, N bits: located value, held until the next accepted start.
REQ-011: Port found, output, 1 bit: result confirmed equal to the target; held with result.

Function
REQ-012: The block shall be a successive-approximation initiator for a combinational comparator; EQ and LT are sampled in the same cycle the probe is driven.
REQ-013: FSM states shall be IDLE, PROBE, VERIFY and DONE.
REQ-014: IDLE with start=1 -> PROBE; bit index i=N-1; trial=0; probe=1<<(N-1).
REQ-015: In PROBE, probe = trial | (1<<i).
REQ-016: PROBE with EQ=1: result<=probe, found<=1, next state DONE (early exit, VERIFY skipped).
REQ-017: PROBE with LT=1 and EQ=0: bit i is kept in trial.
REQ-018: PROBE with LT=0 and EQ=0: bit i is cleared in trial.
REQ-019: After the PROBE decision for i=0, the next state shall be VERIFY with probe=final trial; otherwise i decrements and the FSM stays in PROBE.
REQ-020: VERIFY: result<=trial, found<=EQ, next state DONE.
REQ-021: DONE: done=1 for exactly one cycle, then IDLE; busy=0.
REQ-022: Latency: early exit at step k (k=1..N) gives done k+1 cycles after the start edge; with no early exit done comes N+2 cycles after.
REQ-023: start while busy or in DONE shall be ignored and not queued.
REQ-024: If EQ and LT are both 1 (illegal), EQ shall take priority.
REQ-025: A target change mid-search shall not be detected except through VERIFY; found may be 0.
REQ-026: probe shall be 0 in IDLE and DONE.

Reset
REQ-027: When rst=0 the block shall immediately enter IDLE with probe=0, busy=0, done=0, result=0, found=0, trial=0, i=N-1.
REQ-028: Reset asserted mid-search shall abort the search with no done pulse; the first start after release begins a fresh search.

Structure
REQ-029: State encodings (IDLE=0, PROBE=1, VERIFY=2, DONE=3) and the default N shall live in the shared package sar_pkg.
REQ-030: There shall be no sub-module; the bench connects probe and the target to the team's N-bit comparator (EQ/LT).

Verification
REQ-031: N=8, target=0x80, start pulse: probe=0x80 at cycle 1, EQ -> done at cycle 2, result=0x80, found=1.
REQ-032: Target=0xFF: probes 0x80,0xC0,...,0xFF; EQ on step 8 -> done at cycle 9, result=0xFF, found=1.
REQ-033: Target=0x00: probes 0x80,0x40,...,0x01, then VERIFY probe=0x00 -> done at cycle 10, result=0x00, found=1.
REQ-034: Target=0x5A: result=0x5A and found=1; start pulsed mid-search is ignored, with exactly one done pulse.
REQ-035: Target changed 0x5A->0x10 at step 4: result shall not equal 0x10 and found=0, or found reflects EQ in VERIFY.
REQ-036: rst=0 at step 3: all outputs return to 0 immediately with no done; a new start on target 0x33 gives result=0x33 and found=1.
